// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result and byte-adder signals between the datapath, alu_seq and the 8-bit adder.
interface alu_seq_if #(parameter int NBYTES = 2);
    localparam int W = 8 * NBYTES;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         flag_c;
    logic         flag_v;
    logic         flag_z;
    logic         flag_n;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_ci;
    logic [2:0]   add_fs;
    logic [7:0]   add_y;
    logic         add_c;
    logic         add_v;
    modport master (
        output start, op, opa, opb, add_y, add_c, add_v,
        input  busy, done, result, flag_c, flag_v, flag_z, flag_n, add_a, add_b, add_ci, add_fs
    );
    modport slave (
        input  start, op, opa, opb, add_y, add_c, add_v,
        output busy, done, result, flag_c, flag_v, flag_z, flag_n, add_a, add_b, add_ci, add_fs
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-byte ADD/ADC/SUB/SBC sequencer feeding one 8-bit adder a byte per clock, LSB first.
module alu_seq #(
    parameter int NBYTES = 2
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [W-1:0]  a_r, b_r, shadow, shadow_n, result;
    logic [IW-1:0] idx;
    logic          cy, last, load, run;
    logic          flag_c, flag_v, flag_z, flag_n;
    logic [2:0]    fs;

    always_comb begin
        run      = state == RUN;
        last     = idx == IW'(NBYTES - 1);
        load     = bus.start && !run;
        state_n  = run ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
        shadow_n = shadow;
        shadow_n[{idx, 3'b000} +: 8] = bus.add_y;
    end

    assign bus.busy   = run;
    assign bus.done   = state == DONE;
    assign bus.add_a  = run ? a_r[{idx, 3'b000} +: 8] : 8'h00;
    assign bus.add_b  = run ? b_r[{idx, 3'b000} +: 8] : 8'h00;
    assign bus.add_ci = run & cy;
    assign bus.add_fs = fs;
    assign bus.result = result;
    assign bus.flag_c = flag_c;
    assign bus.flag_v = flag_v;
    assign bus.flag_z = flag_z;
    assign bus.flag_n = flag_n;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    // Subtraction is A + ~B + carry; the carry-in is 0/1 for ADD/SUB and the old C for ADC/SBC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            shadow <= '0;
            result <= '0;
            idx    <= '0;
            cy     <= 1'b0;
            fs     <= 3'b000;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (load) begin
            a_r <= bus.opa;
            b_r <= bus.op[1] ? ~bus.opb : bus.opb;
            cy  <= bus.op[0] ? flag_c : bus.op[1];
            fs  <= {2'b00, bus.op[1]};
            idx <= '0;
        end else if (run) begin
            shadow <= shadow_n;
            cy     <= bus.add_c;
            idx    <= last ? '0 : idx + 1'b1;
            if (last) begin
                result <= shadow_n;
                flag_c <= bus.add_c;
                flag_v <= bus.add_v;
                flag_z <= shadow_n == '0;
                flag_n <= shadow_n[W-1];
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table plus protocol sequences for alu_seq, with a behavioural 8-bit adder and a result scoreboard.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    alu_seq_if #(.NBYTES(2)) bus();
    alu_seq #(.NBYTES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Plain 8-bit adder; operand inversion for subtraction happens upstream in the sequencer.
    assign {bus.add_c, bus.add_y} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'h00, bus.add_ci};
    assign bus.add_v = (bus.add_a[7] == bus.add_b[7]) && (bus.add_y[7] != bus.add_a[7]);

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] r;
        logic        c, v, z, n;
    } vec_t;

    vec_t        vecs[10];
    logic [19:0] sb[$];
    logic [15:0] last_res = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic [15:0] r,
                                input logic c, input logic v, input logic z, input logic n);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.cin = cin; t.r = r;
        t.c = c; t.v = v; t.z = z; t.n = n;
        return t;
    endfunction

    always @(negedge clk)
        if (!rst && bus.done) begin
            if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                logic [19:0] e;
                e = sb.pop_front();
                chk("done_result_flags", {12'h0, bus.result, bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}, {12'h0, e});
                last_res = e[19:4];
            end
        end

    task automatic start_vec(input vec_t v);
        bus.start = 1'b1;
        bus.op    = v.op;
        bus.opa   = v.a;
        bus.opb   = v.b;
        sb.push_back({v.r, v.c, v.v, v.z, v.n});
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        start_vec(v);
        @(negedge clk);
        bus.start = 1'b0;
        chk("run1_busy", {31'h0, bus.busy}, 32'd1);
        chk("run1_done", {31'h0, bus.done}, 32'd0);
        chk("run1_ci", {31'h0, bus.add_ci}, {31'h0, v.cin});
        chk("run1_fs", {29'h0, bus.add_fs}, {30'h0, 1'b0, v.op[1]});
        @(negedge clk);
        chk("run2_busy", {31'h0, bus.busy}, 32'd1);
        chk("run2_no_partial", {16'h0, bus.result}, {16'h0, last_res});
        @(negedge clk);
        chk("done_busy", {31'h0, bus.busy}, 32'd0);
        chk("done_pulse", {31'h0, bus.done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t h;
        vecs[0] = mk(2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 0, 0, 0, 0);
        vecs[1] = mk(2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, 1);
        vecs[2] = mk(2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, 0);
        vecs[3] = mk(2'b01, 16'h0000, 16'h00FF, 1'b1, 16'h0100, 0, 0, 0, 0);
        vecs[4] = mk(2'b10, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1, 0, 1, 0);
        vecs[5] = mk(2'b10, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 0, 0, 0, 1);
        vecs[6] = mk(2'b11, 16'h0005, 16'h0003, 1'b0, 16'h0001, 1, 0, 0, 0);
        vecs[7] = mk(2'b10, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1, 1, 0, 0);
        vecs[8] = mk(2'b01, 16'h1234, 16'h1111, 1'b1, 16'h2346, 0, 0, 0, 0);
        vecs[9] = mk(2'b11, 16'h0010, 16'h0001, 1'b0, 16'h000E, 1, 0, 0, 0);
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.opa   = 16'h0000;
        bus.opb   = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {bus.busy, bus.done, bus.result, bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n,
                              bus.add_a, bus.add_b, bus.add_ci, bus.add_fs},
            32'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        @(negedge clk);
        chk("idle_add_a", {24'h0, bus.add_a}, 32'd0);
        chk("idle_fs_hold", {29'h0, bus.add_fs}, 32'd1);

        // START held through RUN with changing operands must be ignored.
        h = mk(2'b00, 16'h0001, 16'h0002, 1'b0, 16'h0003, 0, 0, 0, 0);
        start_vec(h);
        @(negedge clk);
        bus.opa = 16'hAAAA;
        chk("hold_busy1", {31'h0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.opa = 16'h5555;
        chk("hold_busy2", {31'h0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("hold_done", {31'h0, bus.done}, 32'd1);

        // Back-to-back: new START accepted during the DONE cycle.
        run_vec(mk(2'b00, 16'h0100, 16'h0200, 1'b0, 16'h0300, 0, 0, 0, 0));
        start_vec(mk(2'b10, 16'h0300, 16'h0001, 1'b1, 16'h02FF, 1, 0, 0, 0));
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", {31'h0, bus.busy}, 32'd1);
        chk("b2b_done_drop", {31'h0, bus.done}, 32'd0);
        @(negedge clk);
        chk("b2b_busy2", {31'h0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("b2b_done", {31'h0, bus.done}, 32'd1);

        // Reset in the second RUN cycle aborts without a DONE pulse.
        @(negedge clk);
        start_vec(vecs[1]);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_state", {bus.busy, bus.done, bus.result, bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}, 32'h0);
        sb.delete();
        last_res = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'h0, bus.done}, 32'd0);
        end
        run_vec(mk(2'b00, 16'h0003, 16'h0004, 1'b0, 16'h0007, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
